// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Pulls the shared open-drain PS/2 pins low only through registered pulldown
// enables, and raises rx_inhibit while busy so the receive path ignores the
// clock edges of this transfer.
// Optional build macro PS2_TX_RETRY_EN: a failed frame is retried up to two
// more times before tx_error is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10800,
    parameter int FIRST_TIMEOUT  = 1350000,
    parameter int PACKET_TIMEOUT = 180000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       main_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_pulldown,
    output logic       ps2_data_pulldown
);
    localparam int INH_W   = $clog2(INHIBIT_CYCLES + 1);
    localparam int FIRST_W = $clog2(FIRST_TIMEOUT + 1);
    localparam int PKT_W   = $clog2(PACKET_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        START,
        BITS,
        ACK,
        RELEASE,
        ABORT
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] clock_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clock_prev;
    logic                   clock_s;
    logic                   data_s;
    logic                   fall;

    logic [8:0]         shift_reg;
    logic [3:0]         bit_cnt;
    logic [INH_W-1:0]   inhibit_cnt;
    logic [FIRST_W-1:0] first_timer;
    logic [PKT_W-1:0]   packet_timer;
    logic               first_expired;
    logic               packet_expired;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_cnt;
    logic [7:0] byte_latch;
`endif

    assign clock_s        = clock_sync[SYNC_STAGES-1];
    assign data_s         = data_sync[SYNC_STAGES-1];
    assign fall           = clock_prev & ~clock_s;
    assign first_expired  = (first_timer >= FIRST_W'(FIRST_TIMEOUT));
    assign packet_expired = (packet_timer >= PKT_W'(PACKET_TIMEOUT));

    // Bring the asynchronous pin levels into main_clk and keep the previous clock for edge detection
    always_ff @(posedge main_clk) begin
        if (reset) begin
            clock_sync <= '1;
            data_sync  <= '1;
            clock_prev <= 1'b1;
        end else begin
            clock_sync <= {clock_sync[SYNC_STAGES-2:0], ps2_clock_in};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
            clock_prev <= clock_s;
        end
    end

    // Frame sequencer: inhibit, request-to-send, shift bits on device falling edges, collect ack
    always_ff @(posedge main_clk) begin
        if (reset) begin
            state              <= IDLE;
            tx_ready           <= 1'b1;
            tx_done            <= 1'b0;
            tx_error           <= 1'b0;
            rx_inhibit         <= 1'b0;
            ps2_clock_pulldown <= 1'b0;
            ps2_data_pulldown  <= 1'b0;
            shift_reg          <= '0;
            bit_cnt            <= '0;
            inhibit_cnt        <= '0;
            first_timer        <= '0;
            packet_timer       <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt          <= '0;
            byte_latch         <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            if ((state == BITS || state == ACK || state == RELEASE) && packet_timer != '1)
                packet_timer <= packet_timer + PKT_W'(1);

            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift_reg          <= {~^tx_data, tx_data};
                        inhibit_cnt        <= '0;
                        ps2_clock_pulldown <= 1'b1;
                        tx_ready           <= 1'b0;
                        rx_inhibit         <= 1'b1;
                        state              <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        byte_latch         <= tx_data;
                        retry_cnt          <= '0;
`endif
                    end
                end

                INHIBIT: begin
                    if (inhibit_cnt >= INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_pulldown <= 1'b1;
                        state             <= REQ;
                    end else begin
                        inhibit_cnt <= inhibit_cnt + INH_W'(1);
                    end
                end

                REQ: begin
                    ps2_clock_pulldown <= 1'b0;
                    first_timer        <= '0;
                    state              <= START;
                end

                START: begin
                    if (fall) begin
                        ps2_data_pulldown <= ~shift_reg[0];
                        shift_reg         <= {1'b0, shift_reg[8:1]};
                        bit_cnt           <= 4'd1;
                        packet_timer      <= '0;
                        state             <= BITS;
                    end else if (first_expired) begin
                        ps2_data_pulldown  <= 1'b0;
                        ps2_clock_pulldown <= 1'b0;
                        state              <= ABORT;
                    end else if (first_timer != '1) begin
                        first_timer <= first_timer + FIRST_W'(1);
                    end
                end

                BITS: begin
                    if (packet_expired) begin
                        ps2_data_pulldown  <= 1'b0;
                        ps2_clock_pulldown <= 1'b0;
                        state              <= ABORT;
                    end else if (fall) begin
                        if (bit_cnt == 4'd9) begin
                            ps2_data_pulldown <= 1'b0;
                            state             <= ACK;
                        end else begin
                            ps2_data_pulldown <= ~shift_reg[0];
                            shift_reg         <= {1'b0, shift_reg[8:1]};
                            bit_cnt           <= bit_cnt + 4'd1;
                        end
                    end
                end

                ACK: begin
                    if (packet_expired || (clock_s && data_s)) begin
                        ps2_data_pulldown  <= 1'b0;
                        ps2_clock_pulldown <= 1'b0;
                        state              <= ABORT;
                    end else if (fall && !data_s) begin
                        state <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (packet_expired) begin
                        ps2_data_pulldown  <= 1'b0;
                        ps2_clock_pulldown <= 1'b0;
                        state              <= ABORT;
                    end else if (clock_s && data_s) begin
                        tx_done    <= 1'b1;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state      <= IDLE;
                    end
                end

                ABORT: begin
`ifdef PS2_TX_RETRY_EN
                    if (retry_cnt < 2'd2) begin
                        retry_cnt          <= retry_cnt + 2'd1;
                        shift_reg          <= {~^byte_latch, byte_latch};
                        inhibit_cnt        <= '0;
                        ps2_clock_pulldown <= 1'b1;
                        state              <= INHIBIT;
                    end else begin
                        tx_error   <= 1'b1;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state      <= IDLE;
                    end
`else
                    tx_error   <= 1'b1;
                    tx_ready   <= 1'b1;
                    rx_inhibit <= 1'b0;
                    state      <= IDLE;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
